// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the HI/LO multiply/divide execute-stage controller:
// op encodings, FSM state encoding, datapath width and the {hi,lo} pair type.
// -----------------------------------------------------------------------------
package muldiv_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MUL_RUN = 3'd1,
        ST_DIV_RUN = 3'd2,
        ST_DONE    = 3'd3,
        ST_ABORT   = 3'd4
    } state_e;

    // Packed so that a 64-bit unit result casts directly: hi = [63:32].
    typedef struct packed {
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
    } hilo_t;

    // Bit 1 of the op selects the divider; bit 0 selects unsigned.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
// Execute-stage sequencer for the external iterative multiplier and divider.
// Accepts one MULT/MULTU/DIV/DIVU request, holds latched operands on the
// selected unit, stalls the pipeline until the unit is ready, then strobes a
// HI/LO write. Handles flush (annul), divide-by-zero bypass and a watchdog.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   flush_i                  cancels any operation in progress
//   req_valid_i/req_op_i     request from EX (held while stall_o=1)
//   req_src1_i/req_src2_i    rs / rt operands
//   stall_o                  freeze IF/ID/EX
//   hilo_we_o, hi_o, lo_o    one-cycle write strobe and registered HI/LO
//   err_timeout_o            sticky watchdog flag
//   mul_*                    multiplier handshake, operands and {HI,LO} result
//   div_*                    divider handshake, operands and {rem,quot} result
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for a request; accept cycle stalls combinationally
// ST_MUL_RUN | multiplier started, operands held, waiting for ready
// ST_DIV_RUN | divider started, operands held, waiting for ready
// ST_DONE    | one cycle: start dropped, HI/LO write strobe unless flushed
// ST_ABORT   | one cycle: annul the selected unit, no write
// -----------------------------------------------------------------------------
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int TIMEOUT_CYC = 63
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_i,
    input  logic                req_valid_i,
    input  logic [1:0]          req_op_i,
    input  logic [DATA_W-1:0]   req_src1_i,
    input  logic [DATA_W-1:0]   req_src2_i,
    output logic                stall_o,
    output logic                hilo_we_o,
    output logic [DATA_W-1:0]   hi_o,
    output logic [DATA_W-1:0]   lo_o,
    output logic                err_timeout_o,
    output logic                mul_start_o,
    output logic                mul_annul_o,
    output logic                mul_signed_o,
    output logic [DATA_W-1:0]   mul_op1_o,
    output logic [DATA_W-1:0]   mul_op2_o,
    input  logic [2*DATA_W-1:0] mul_result_i,
    input  logic                mul_ready_i,
    output logic                div_start_o,
    output logic                div_annul_o,
    output logic                div_signed_o,
    output logic [DATA_W-1:0]   div_op1_o,
    output logic [DATA_W-1:0]   div_op2_o,
    input  logic [2*DATA_W-1:0] div_result_i,
    input  logic                div_ready_i
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    // The watchdog holds the number of completed RUN cycles, so the RUN cycle
    // that sees this value is the TIMEOUT_CYC-th one.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    state_e              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [DATA_W-1:0]   src1_q, src1_d;
    logic [DATA_W-1:0]   src2_q, src2_d;
    hilo_t               hilo_q, hilo_d;
    logic [WD_W-1:0]     wdog_q, wdog_d;
    logic                err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
            hilo_q  <= '0;
            wdog_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            hilo_q  <= hilo_d;
            wdog_q  <= wdog_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        src1_d       = src1_q;
        src2_d       = src2_q;
        hilo_d       = hilo_q;
        wdog_d       = wdog_q;
        err_d        = err_q;
        stall_o      = 1'b0;
        hilo_we_o    = 1'b0;
        mul_start_o  = 1'b0;
        mul_annul_o  = 1'b0;
        mul_signed_o = 1'b0;
        mul_op1_o    = '0;
        mul_op2_o    = '0;
        div_start_o  = 1'b0;
        div_annul_o  = 1'b0;
        div_signed_o = 1'b0;
        div_op1_o    = '0;
        div_op2_o    = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid_i && !flush_i) begin
                    stall_o = 1'b1;
                    op_d    = req_op_i;
                    src1_d  = req_src1_i;
                    src2_d  = req_src2_i;
                    wdog_d  = '0;
                    if (!op_is_div(req_op_i)) begin
                        state_d = ST_MUL_RUN;
                    end else if (req_src2_i == '0) begin
                        // Divide by zero never reaches the divider.
                        hilo_d  = '0;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DIV_RUN;
                    end
                end
            end

            ST_MUL_RUN: begin
                stall_o      = 1'b1;
                mul_start_o  = 1'b1;
                mul_signed_o = op_is_signed(op_q);
                mul_op1_o    = src1_q;
                mul_op2_o    = src2_q;
                wdog_d       = wdog_q + 1'b1;
                // Flush wins over a simultaneous ready.
                if (flush_i) begin
                    state_d = ST_ABORT;
                end else if (mul_ready_i) begin
                    hilo_d  = hilo_t'(mul_result_i);
                    state_d = ST_DONE;
                end else if (wdog_q == WD_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_ABORT;
                end
            end

            ST_DIV_RUN: begin
                stall_o      = 1'b1;
                div_start_o  = 1'b1;
                div_signed_o = op_is_signed(op_q);
                div_op1_o    = src1_q;
                div_op2_o    = src2_q;
                wdog_d       = wdog_q + 1'b1;
                if (flush_i) begin
                    state_d = ST_ABORT;
                end else if (div_ready_i) begin
                    hilo_d  = hilo_t'(div_result_i);
                    state_d = ST_DONE;
                end else if (wdog_q == WD_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_ABORT;
                end
            end

            ST_DONE: begin
                // Result is already in hilo_q; a flush here only suppresses
                // the architectural write.
                hilo_we_o = ~flush_i;
                state_d   = ST_IDLE;
            end

            ST_ABORT: begin
                mul_annul_o = ~op_is_div(op_q);
                div_annul_o = op_is_div(op_q);
                state_d     = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign hi_o          = hilo_q.hi;
    assign lo_o          = hilo_q.lo;
    assign err_timeout_o = err_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        req_valid_i;
    logic [1:0]  req_op_i;
    logic [31:0] req_src1_i;
    logic [31:0] req_src2_i;
    logic        stall_o;
    logic        hilo_we_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        err_timeout_o;
    logic        mul_start_o, mul_annul_o, mul_signed_o;
    logic [31:0] mul_op1_o, mul_op2_o;
    logic [63:0] mul_result_i;
    logic        mul_ready_i;
    logic        div_start_o, div_annul_o, div_signed_o;
    logic [31:0] div_op1_o, div_op2_o;
    logic [63:0] div_result_i;
    logic        div_ready_i;

    int checks = 0;
    int errors = 0;

    muldiv_ctrl #(.TIMEOUT_CYC(63)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .req_valid_i  (req_valid_i),
        .req_op_i     (req_op_i),
        .req_src1_i   (req_src1_i),
        .req_src2_i   (req_src2_i),
        .stall_o      (stall_o),
        .hilo_we_o    (hilo_we_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o),
        .err_timeout_o(err_timeout_o),
        .mul_start_o  (mul_start_o),
        .mul_annul_o  (mul_annul_o),
        .mul_signed_o (mul_signed_o),
        .mul_op1_o    (mul_op1_o),
        .mul_op2_o    (mul_op2_o),
        .mul_result_i (mul_result_i),
        .mul_ready_i  (mul_ready_i),
        .div_start_o  (div_start_o),
        .div_annul_o  (div_annul_o),
        .div_signed_o (div_signed_o),
        .div_op1_o    (div_op1_o),
        .div_op2_o    (div_op2_o),
        .div_result_i (div_result_i),
        .div_ready_i  (div_ready_i)
    );

    always #5 clk = ~clk;

    // Multiplier model: ready visible 34 cycles after the first start-high sample.
    localparam int MUL_LAT = 34;
    int mul_cnt;
    always @(posedge clk) begin
        if (rst || !mul_start_o) begin
            mul_cnt     <= 0;
            mul_ready_i <= 1'b0;
        end else if (mul_cnt < MUL_LAT) begin
            mul_cnt     <= mul_cnt + 1;
            mul_ready_i <= (mul_cnt + 1 == MUL_LAT);
        end
    end
    always_comb begin
        if (mul_signed_o)
            mul_result_i = {{32{mul_op1_o[31]}}, mul_op1_o} * {{32{mul_op2_o[31]}}, mul_op2_o};
        else
            mul_result_i = {32'd0, mul_op1_o} * {32'd0, mul_op2_o};
    end

    // Divider stub: fixed {rem=2, quot=14}, configurable latency, can hang.
    int div_lat   = 10;
    bit div_never = 1'b0;
    int div_cnt;
    assign div_result_i = {32'd2, 32'd14};
    always @(posedge clk) begin
        if (rst || !div_start_o) begin
            div_cnt     <= 0;
            div_ready_i <= 1'b0;
        end else if (div_cnt < div_lat) begin
            div_cnt     <= div_cnt + 1;
            div_ready_i <= !div_never && (div_cnt + 1 == div_lat);
        end
    end

    int we_cnt = 0, mann_cnt = 0, dann_cnt = 0, dstart_cnt = 0;
    always @(posedge clk) begin
        if (hilo_we_o)   we_cnt     <= we_cnt + 1;
        if (mul_annul_o) mann_cnt   <= mann_cnt + 1;
        if (div_annul_o) dann_cnt   <= dann_cnt + 1;
        if (div_start_o) dstart_cnt <= dstart_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one request at posedge+1 (cycle 0 = accept) and runs until stall_o
    // drops. n = index of the first non-stalled cycle. Returns at posedge+1 of
    // the following cycle so another op can follow with no gap.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int flush_cyc, input bit flush_done,
                          output int n, output int stalls, output logic we, output logic ann);
        bit fin;
        req_valid_i = 1'b1;
        req_op_i    = op;
        req_src1_i  = a;
        req_src2_i  = b;
        flush_i     = 1'b0;
        n      = 0;
        stalls = 0;
        fin    = 1'b0;
        while (!fin) begin
            @(negedge clk);
            if (!stall_o || n >= 200) begin
                fin = 1'b1;
            end else begin
                stalls++;
                @(posedge clk);
                #1;
                n++;
                flush_i = (n == flush_cyc);
            end
        end
        if (flush_done) begin
            flush_i = 1'b1;
            #1;
        end
        we  = hilo_we_o;
        ann = mul_annul_o | div_annul_o;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        flush_i     = 1'b0;
    endtask

    int   n, st, w0, a0;
    logic we, ann;

    initial begin
        rst         = 1'b1;
        flush_i     = 1'b0;
        req_valid_i = 1'b0;
        req_op_i    = 2'b00;
        req_src1_i  = '0;
        req_src2_i  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ctrl", {57'd0, stall_o, hilo_we_o, err_timeout_o, mul_start_o, mul_annul_o,
                         div_start_o, div_annul_o}, 64'd0);
        chk("rst_hilo", {hi_o, lo_o}, 64'd0);
        chk("rst_opnd", {mul_op1_o | mul_op2_o, div_op1_o | div_op2_o}, 64'd0);
        @(posedge clk);
        #1;

        // Flush in IDLE: nothing accepted.
        req_valid_i = 1'b1; req_op_i = 2'b00; req_src1_i = 32'd3; req_src2_i = 32'd3;
        flush_i = 1'b1;
        #1;
        chk("idle_flush_stall", {63'd0, stall_o}, 64'd0);
        @(posedge clk);
        #1;
        req_valid_i = 1'b0; flush_i = 1'b0;
        chk("idle_flush_nostart", {63'd0, mul_start_o}, 64'd0);

        // MULT -3 x 5
        w0 = we_cnt;
        run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, -1, 1'b0, n, st, we, ann);
        chk("mult_stall", 64'(st), 64'd36);
        chk("mult_we_cyc", 64'(n), 64'd36);
        chk("mult_we", {63'd0, we}, 64'd1);
        chk("mult_hilo", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFF1);
        chk("mult_we_cnt", 64'(we_cnt - w0), 64'd1);

        // MULTU then MULT back-to-back
        w0 = we_cnt;
        run_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, -1, 1'b0, n, st, we, ann);
        chk("multu_hilo", {hi_o, lo_o}, 64'h0000_0001_FFFF_FFFE);
        run_op(2'b00, 32'd7, 32'd6, -1, 1'b0, n, st, we, ann);
        chk("b2b_stall", 64'(st), 64'd36);
        chk("b2b_hilo", {hi_o, lo_o}, 64'h0000_0000_0000_002A);
        chk("b2b_we_cnt", 64'(we_cnt - w0), 64'd2);

        // DIV 5/0 bypass
        a0 = dstart_cnt;
        run_op(2'b10, 32'd5, 32'd0, -1, 1'b0, n, st, we, ann);
        chk("dz_stall", 64'(st), 64'd1);
        chk("dz_we_cyc", {31'd0, we, 32'(n)}, {31'd0, 1'b1, 32'd1});
        chk("dz_hilo", {hi_o, lo_o}, 64'd0);
        chk("dz_nostart", 64'(dstart_cnt - a0), 64'd0);

        // DIVU 100/7 with 10-cycle stub
        run_op(2'b11, 32'd100, 32'd7, -1, 1'b0, n, st, we, ann);
        chk("divu_stall", 64'(st), 64'd12);
        chk("divu_we", {63'd0, we}, 64'd1);
        chk("divu_hilo", {hi_o, lo_o}, {32'd2, 32'd14});

        // Flush during MULT RUN cycle 10
        w0 = we_cnt; a0 = mann_cnt;
        run_op(2'b00, 32'd9, 32'd9, 10, 1'b0, n, st, we, ann);
        chk("flush_rel_cyc", 64'(n), 64'd11);
        chk("flush_annul", {62'd0, ann, we}, {62'd0, 1'b1, 1'b0});
        chk("flush_annul_cnt", 64'(mann_cnt - a0), 64'd1);
        chk("flush_no_we", 64'(we_cnt - w0), 64'd0);
        chk("flush_hilo", {hi_o, lo_o}, {32'd2, 32'd14});
        run_op(2'b00, 32'd7, 32'd6, -1, 1'b0, n, st, we, ann);
        chk("post_flush_op", {hi_o, lo_o, 32'(st)}, {64'h2A, 32'd36});

        // Flush coincident with DONE
        w0 = we_cnt;
        run_op(2'b01, 32'd3, 32'd4, -1, 1'b1, n, st, we, ann);
        chk("done_flush_we", {63'd0, we}, 64'd0);
        chk("done_flush_cnt", 64'(we_cnt - w0), 64'd0);
        chk("done_flush_hilo", {hi_o, lo_o}, 64'hC);

        // Flush coincident with mul_ready (visible in cycle 35)
        a0 = mann_cnt;
        run_op(2'b00, 32'd2, 32'd2, 35, 1'b0, n, st, we, ann);
        chk("rdy_flush_cyc", 64'(n), 64'd36);
        chk("rdy_flush_abort", {62'd0, ann, we}, {62'd0, 1'b1, 1'b0});
        chk("rdy_flush_hilo", {hi_o, lo_o}, 64'hC);

        // Watchdog timeout with a hung divider
        div_never = 1'b1;
        a0 = dann_cnt; w0 = we_cnt;
        run_op(2'b11, 32'd10, 32'd3, -1, 1'b0, n, st, we, ann);
        chk("to_stall", 64'(st), 64'd64);
        chk("to_err", {63'd0, err_timeout_o}, 64'd1);
        chk("to_annul_cnt", 64'(dann_cnt - a0), 64'd1);
        chk("to_no_we", 64'(we_cnt - w0), 64'd0);
        chk("to_hilo", {hi_o, lo_o}, 64'hC);
        div_never = 1'b0;
        run_op(2'b00, 32'd7, 32'd6, -1, 1'b0, n, st, we, ann);
        chk("to_sticky", {63'd0, err_timeout_o}, 64'd1);

        // rst mid-operation
        req_valid_i = 1'b1; req_op_i = 2'b00; req_src1_i = 32'd1; req_src2_i = 32'd1;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        chk("mid_run_start", {63'd0, mul_start_o}, 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_ctrl", {59'd0, stall_o, mul_start_o, mul_annul_o, err_timeout_o, hilo_we_o},
            64'd0);
        chk("mid_rst_hilo", {hi_o, lo_o}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Execute-stage controller that sequences the 32-bit iterative multiplier and divider units for HI/LO instructions (MULT, MULTU, DIV, DIVU).
- Accepts one request from EX, latches the operands and holds them stable on the selected unit for the whole operation.
- Drives the start/annul handshake, stalls the pipeline until the unit reports ready, then writes HI/LO.
- Handles flush, divide-by-zero bypass and a watchdog timeout. Both units are instantiated beside it by the parent.

Parameters:
TIMEOUT_CYC, 63, maximum consecutive RUN cycles without unit ready before abort (must be >= 40)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
flush_i  in  1  pipeline flush; cancels any operation in progress
req_valid_i  in  1  EX holds a mul/div op; held stable while stall_o=1
req_op_i  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
req_src1_i  in  32  rs operand
req_src2_i  in  32  rt operand
stall_o  out  1  freeze IF/ID/EX
hilo_we_o  out  1  one-cycle HI/LO write strobe
hi_o  out  32  HI value
lo_o  out  32  LO value
err_timeout_o  out  1  sticky watchdog flag
mul_start_o, mul_annul_o, mul_signed_o  out  1 each  multiplier control
mul_op1_o, mul_op2_o  out  32 each  multiplier operands
mul_result_i  in  64  {HI,LO} product
mul_ready_i  in  1  multiplier done
div_start_o, div_annul_o, div_signed_o  out  1 each  divider control
div_op1_o, div_op2_o  out  32 each  dividend, divisor
div_result_i  in  64  {remainder,quotient}
div_ready_i  in  1  divider done

Behaviour:
- Reset: state IDLE; all outputs 0; op/operand latches, hi/lo regs, watchdog and err flag cleared.
- States: IDLE, MUL_RUN, DIV_RUN, DONE, ABORT.
- IDLE, req_valid_i=1 and flush_i=0: latch op, src1, src2.
  - Op 0x: next state MUL_RUN.
  - Op 1x with src2=0: hi/lo regs <= 0, next state DONE (bypass).
  - Op 1x with src2!=0: next state DIV_RUN.
  - stall_o=1 combinationally in the accept cycle.
- IDLE with flush_i=1: nothing accepted; stall_o=0.
- MUL_RUN/DIV_RUN:
  - Selected start_o=1; op1/op2 driven from the latches, constant until state exit.
  - signed_o = ~op[0].
  - The other unit's start/annul = 0; its operand outputs = 0.
  - stall_o=1; watchdog increments each cycle.
- Ready seen in RUN: capture result_i into HI/LO regs (HI=[63:32], LO=[31:0]; for the divider HI=remainder, LO=quotient); next state DONE.
- DONE (exactly one cycle):
  - start_o=0, which returns the unit to idle.
  - stall_o=0.
  - hilo_we_o = ~flush_i.
  - Next state IDLE.
  - A request present in the following IDLE cycle is a new op; back-to-back ops are allowed with zero dead cycles beyond DONE.
- flush_i=1 in RUN (wins over a simultaneous ready): next state ABORT.
- ABORT (exactly one cycle): selected annul_o=1, start_o=0, stall_o=0, no write; next state IDLE.
- Watchdog reaching TIMEOUT_CYC in RUN: err_timeout_o <= 1 (sticky until rst); next state ABORT; no write.
- hi_o/lo_o: registered; hold the last written value; change only on a capture or a div-by-zero bypass.
- Latency:
  - Registered start, so start is first visible in the cycle after accept.
  - Total stall = unit ready latency (cycles from first start-high sample to ready visible) + 1 accept cycle + 1 capture cycle.
  - With the 34-cycle multiplier: stall_o high 36 cycles; hilo_we_o in cycle 36 counting the accept cycle as 0.
- rst mid-operation: immediate return to IDLE. Units are reset by the same rst; no annul is issued.
- Reset terminology: 'rst' is used throughout.

Decomposition:
- Package muldiv_pkg:
  - op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU;
  - state enum constants;
  - DATA_W=32;
  - typedef for the 64-bit {hi,lo} pair.
- No sub-module: watchdog and FSM fit in one module. Units stay external.

Test Plan:
- MULT 0xFFFFFFFD x 0x00000005, real multiplier -> stall_o high 36 cycles; one hilo_we_o; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU 0xFFFFFFFF x 0x00000002, then MULT 7 x 6 issued the cycle after DONE:
  - first op: hi=0x00000001, lo=0xFFFFFFFE;
  - second op: hi=0, lo=0x0000002A;
  - exactly two strobes.
- DIVU 100/7, divider stub returning {2,14} after 10 cycles -> hi=0x2, lo=0xE. DIV 5/0 -> div_start_o never asserted; stall 1 cycle; hi=lo=0; strobe in cycle 1.
- MULT in progress, flush_i at RUN cycle 10 -> mul_annul_o=1 for one cycle; stall_o low from that cycle; no strobe; hi/lo unchanged; next op accepted normally.
- flush_i coincident with the DONE cycle -> hilo_we_o=0, hi/lo regs updated but not architecturally written. flush_i coincident with mul_ready_i -> ABORT path.
- Divider stub never ready, TIMEOUT_CYC=63 -> err_timeout_o rises after 63 RUN cycles, one div_annul_o pulse, stall released, flag stays set until rst.
